// File: rtl/fan_route.sv
// fan_route: one-word-per-channel fan-out router with unicast and broadcast loads.
// Optional build macro FAN_ROUTE_TRISTATE_EN floats empty channels' out_data to 'z.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module fan_route #(
  parameter int SIGNAL_WIDTH = `REG_WIDTH,
  parameter int SEL_WIDTH    = 4,
  localparam int NUM_OUT     = 2**SEL_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SIGNAL_WIDTH-1:0]         in_data,
  input  logic [SEL_WIDTH-1:0]            in_sel,
  input  logic                            in_bcast,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_OUT*SIGNAL_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [SEL_WIDTH:0]              occupancy
);

  logic [NUM_OUT-1:0]      valid;
  logic [NUM_OUT-1:0]      drain;
  logic [NUM_OUT-1:0]      avail;
  logic [NUM_OUT-1:0]      load;
  logic [NUM_OUT-1:0]      valid_next;
  logic [SIGNAL_WIDTH-1:0] slot [NUM_OUT];
  logic                    xfer;
  logic [SEL_WIDTH:0]      count_next;

  // A slot can take a word if it is empty or its current word leaves this cycle.
  assign drain    = valid & out_ready;
  assign avail    = ~valid | drain;
  assign in_ready = in_bcast ? &avail : avail[in_sel];
  assign xfer     = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (xfer) begin
      if (in_bcast) load = '1;
      else          load[in_sel] = 1'b1;
    end
    valid_next = (valid & ~drain) | load;
    count_next = '0;
    for (int k = 0; k < NUM_OUT; k++)
      count_next = count_next + (SEL_WIDTH+1)'(valid_next[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int k = 0; k < NUM_OUT; k++) slot[k] <= '0;
    end else begin
      valid     <= valid_next;
      occupancy <= count_next;
      for (int k = 0; k < NUM_OUT; k++)
        if (load[k]) slot[k] <= in_data;
    end
  end

  assign out_valid = valid;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
`ifdef FAN_ROUTE_TRISTATE_EN
    assign out_data[g*SIGNAL_WIDTH +: SIGNAL_WIDTH] = valid[g] ? slot[g] : {SIGNAL_WIDTH{1'bz}};
`else
    assign out_data[g*SIGNAL_WIDTH +: SIGNAL_WIDTH] = slot[g];
`endif
  end

endmodule

// File: tb/tb_fan_route.sv
// Self-checking bench for fan_route (SIGNAL_WIDTH=8, SEL_WIDTH=4): directed cases
// plus random unicast traffic against a per-channel queue scoreboard.
module tb_fan_route;

  localparam int W = 8;
  localparam int S = 4;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic           in_bcast;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [S:0]     occupancy;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference: each channel is a queue of words delivered but not yet consumed,
  // plus the last word written to it (what a non-tristate channel shows when empty).
  logic [W-1:0] pend [N][$];
  logic [W-1:0] last_word [N];

  fan_route #(.SIGNAL_WIDTH(W), .SEL_WIDTH(S)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      pend[k].delete();
      last_word[k] = '0;
    end
  endtask

  task automatic compare_state();
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    int             eo;
    ev = '0;
    ed = '0;
    eo = 0;
    for (int k = 0; k < N; k++) begin
      eo += pend[k].size();
      if (pend[k].size() > 0) begin
        ev[k] = 1'b1;
        ed[k*W +: W] = pend[k][0];
      end else begin
`ifdef FAN_ROUTE_TRISTATE_EN
        ed[k*W +: W] = {W{1'bz}};
`else
        ed[k*W +: W] = last_word[k];
`endif
      end
    end
    checkOutput("out_valid", out_valid, ev);
    checkOutput("occupancy", occupancy, eo);
    checkOutput("out_data", out_data, ed);
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, advance the model, check after.
  task automatic applyStimulus(input logic v, input logic [S-1:0] sel, input logic b,
                               input logic [W-1:0] d, input logic [N-1:0] ordy, output logic rdy);
    logic exp_rdy;
    in_valid  = v;
    in_sel    = sel;
    in_bcast  = b;
    in_data   = d;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    exp_rdy = 1'b1;
    for (int k = 0; k < N; k++)
      if ((b || k == int'(sel)) && pend[k].size() > 0 && !ordy[k]) exp_rdy = 1'b0;
    checkOutput("in_ready", rdy, exp_rdy);
    for (int k = 0; k < N; k++)
      if (pend[k].size() > 0 && ordy[k]) void'(pend[k].pop_front());
    if (v && exp_rdy)
      for (int k = 0; k < N; k++)
        if (b || k == int'(sel)) begin
          pend[k].push_back(d);
          last_word[k] = d;
        end
    @(posedge clk);
    #1;
    compare_state();
  endtask

  task automatic applyReset(input logic v, input logic [S-1:0] sel, input logic [W-1:0] d);
    rst       = 1'b1;
    in_valid  = v;
    in_sel    = sel;
    in_bcast  = 1'b0;
    in_data   = d;
    out_ready = '1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    compare_state();
  endtask

  initial begin
    logic         r;
    logic [N-1:0] ordy;
    logic         v;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0; out_ready = '0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_state();
    checkOutput("reset_occ", occupancy, 0);

    // Unicast, then a second word to the same full channel is refused.
    applyStimulus(1'b1, 4'd3, 1'b0, 8'hA5, 16'h0000, r);
    checkOutput("uni_valid", out_valid, 16'h0008);
    checkOutput("uni_ch3", out_data[31:24], 8'hA5);
    checkOutput("uni_occ", occupancy, 1);
    applyStimulus(1'b1, 4'd3, 1'b0, 8'h77, 16'h0000, r);
    checkOutput("full_ready", r, 1'b0);

    // Zero-bubble pass: drain and reload channel 3 in one cycle.
    applyStimulus(1'b1, 4'd3, 1'b0, 8'h5A, 16'h0008, r);
    checkOutput("pass_ready", r, 1'b1);
    checkOutput("pass_ch3", out_data[31:24], 8'h5A);
    checkOutput("pass_occ", occupancy, 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, r);

    // Broadcast into empty block, then broadcast blocked by a stuck channel 7.
    applyStimulus(1'b1, 4'd9, 1'b1, 8'h3C, 16'h0000, r);
    checkOutput("bc_valid", out_valid, 16'hFFFF);
    checkOutput("bc_occ", occupancy, 16);
    checkOutput("bc_ch15", out_data[127:120], 8'h3C);
    applyStimulus(1'b1, 4'd0, 1'b1, 8'hC3, 16'hFF7F, r);
    checkOutput("bc_blocked", r, 1'b0);
    checkOutput("bc_left", out_valid, 16'h0080);
    applyStimulus(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF, r);

    // Reset mid-operation with a transfer in flight.
    applyStimulus(1'b1, 4'd0, 1'b0, 8'h01, 16'h0000, r);
    applyStimulus(1'b1, 4'd15, 1'b0, 8'hF0, 16'h0000, r);
    applyReset(1'b1, 4'd5, 8'h99);
    checkOutput("rst_valid", out_valid, 16'h0000);
    checkOutput("rst_occ", occupancy, 0);

    // Drained channel keeps (or floats) its last word.
    applyStimulus(1'b1, 4'd2, 1'b0, 8'h11, 16'h0000, r);
    applyStimulus(1'b0, 4'd2, 1'b0, 8'h00, 16'h0004, r);
    checkOutput("drain_v2", out_valid[2], 1'b0);
`ifdef FAN_ROUTE_TRISTATE_EN
    checkOutput("drain_ch2", out_data[23:16], 8'hzz);
`else
    checkOutput("drain_ch2", out_data[23:16], 8'h11);
`endif

    // Random unicast traffic with random consumers.
    for (int i = 0; i < 1000; i++) begin
      ordy = N'($urandom);
      v    = ($urandom_range(0, 3) != 0);
      applyStimulus(v, S'($urandom_range(0, N-1)), 1'b0, W'($urandom), ordy, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
